// File: rtl/barrel_shift_r_pipe.sv
// Pipelined right barrel shifter: SHAMT_W register stages, one power-of-two shift per stage, full backpressure.
// Define ARITH_SHIFT_EN to honour arith (sign-fill); otherwise every shift is logical and arith is ignored.
module barrel_shift_r_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   shift_str,
    input  logic [SHAMT_W-1:0] shift_amnt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   shifted_str
);

    logic               r_vld  [SHAMT_W];
    logic [WIDTH-1:0]   r_dat  [SHAMT_W];
    logic [SHAMT_W-1:0] r_amt  [SHAMT_W];
    logic               r_fill [SHAMT_W];

    logic               w_src_vld  [SHAMT_W];
    logic [WIDTH-1:0]   w_src_dat  [SHAMT_W];
    logic [SHAMT_W-1:0] w_src_amt  [SHAMT_W];
    logic               w_src_fill [SHAMT_W];
    logic [WIDTH-1:0]   w_step     [SHAMT_W];

    logic w_adv;
    logic w_fill_in;

`ifdef ARITH_SHIFT_EN
    assign w_fill_in = arith & shift_str[WIDTH-1];
`else
    logic w_unused_arith;
    assign w_unused_arith = arith;
    assign w_fill_in      = 1'b0;
`endif

    // Single global enable: the whole pipe moves or the whole pipe holds.
    assign w_adv       = !r_vld[SHAMT_W-1] | out_ready;
    assign in_ready    = w_adv;
    assign out_valid   = r_vld[SHAMT_W-1];
    assign shifted_str = r_dat[SHAMT_W-1];

    always_comb begin
        for (int k = 0; k < SHAMT_W; k++) begin
            if (k == 0) begin
                w_src_vld[k]  = in_valid;
                w_src_dat[k]  = shift_str;
                w_src_amt[k]  = shift_amnt;
                w_src_fill[k] = w_fill_in;
            end else begin
                w_src_vld[k]  = r_vld[k-1];
                w_src_dat[k]  = r_dat[k-1];
                w_src_amt[k]  = r_amt[k-1];
                w_src_fill[k] = r_fill[k-1];
            end
            // Stage k handles amount bit SHAMT_W-1-k, i.e. a shift of 2^(SHAMT_W-1-k).
            if (w_src_amt[k][SHAMT_W-1-k]) begin
                w_step[k] = (w_src_dat[k] >> (1 << (SHAMT_W-1-k)))
                          | (~({WIDTH{1'b1}} >> (1 << (SHAMT_W-1-k))) & {WIDTH{w_src_fill[k]}});
            end else begin
                w_step[k] = w_src_dat[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_vld[k]  <= 1'b0;
                r_dat[k]  <= '0;
                r_amt[k]  <= '0;
                r_fill[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_vld[k]  <= w_src_vld[k];
                r_dat[k]  <= w_step[k];
                r_amt[k]  <= w_src_amt[k];
                r_fill[k] <= w_src_fill[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_r_pipe.sv
// Randomised and directed bench for barrel_shift_r_pipe against a queue-based reference model.
module tb_barrel_shift_r_pipe;

`ifdef ARITH_SHIFT_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] shift_str;
    logic [4:0]  shift_amnt;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shifted_str;

    logic [31:0] exp_in;
    logic [31:0] q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          emit_cnt = 0;
    bit          last_acc = 1'b0;

    always #5 clk = ~clk;

    barrel_shift_r_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift_str   (shift_str),
        .shift_amnt  (shift_amnt),
        .arith       (arith),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .shifted_str (shifted_str)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input bit a);
        if (ARITH_EN && a && x[31]) return ~((~x) >> s);
        return x >> s;
    endfunction

    // One clock: sample handshakes before the edge, update the scoreboard after it.
    task automatic cycle();
        bit          acc, emit, r;
        logic [31:0] got, e;
        #1;
        r    = rst;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        got  = shifted_str;
        e    = exp_in;
        @(posedge clk);
        #1;
        last_acc = acc && !r;
        if (r) begin
            q.delete();
        end else begin
            if (emit) begin
                emit_cnt++;
                if (q.size() == 0) chk("spurious_out", 32'(emit), 32'h0);
                else chk("result", got, q.pop_front());
            end
            if (acc) q.push_back(e);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [4:0] s, input bit a, input logic [31:0] e);
        in_valid   = 1'b1;
        shift_str  = x;
        shift_amnt = s;
        arith      = a;
        exp_in     = e;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] arith_exp [4];
        logic [4:0]  arith_amt [4];
        int          n;
        int          base;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        shift_str = '0; shift_amnt = '0; arith = 1'b0; exp_in = '0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_shifted", shifted_str, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Latency: one word, count edges after acceptance until out_valid is visible.
        drive(32'hD6975971, 5'd4, 1'b0, 32'h0D697597);
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("latency", n, 4);
        drain("drain_latency");

        // Logical, back-to-back, one result per cycle.
        base = emit_cnt;
        drive(32'hD6975971, 5'd4,  1'b0, 32'h0D697597); cycle();
        drive(32'hD6975971, 5'd2,  1'b0, 32'h35A5D65C); cycle();
        drive(32'hD6975971, 5'd10, 1'b0, 32'h0035A5D6); cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        n = 0;
        while (q.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("b2b_drain_cycles", n, 3);
        chk("b2b_count", emit_cnt - base, 3);

        // Arithmetic-request stimulus; logical results when the feature is compiled out.
        arith_amt[0] = 5'd4;  arith_amt[1] = 5'd10; arith_amt[2] = 5'd31; arith_amt[3] = 5'd0;
        if (ARITH_EN) begin
            arith_exp[0] = 32'hFD697597; arith_exp[1] = 32'hFFF5A5D6;
            arith_exp[2] = 32'hFFFFFFFF; arith_exp[3] = 32'hD6975971;
        end else begin
            arith_exp[0] = 32'h0D697597; arith_exp[1] = 32'h0035A5D6;
            arith_exp[2] = 32'h00000001; arith_exp[3] = 32'hD6975971;
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'hD6975971, arith_amt[i], 1'b1, arith_exp[i]);
            cycle();
        end
        drain("drain_arith");

        // Backpressure: fill five stages, hold the output for three cycles.
        base = emit_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(32'h80000000 | (32'h11111111 * (i + 1)), 5'(3 * i + 1), 1'(i & 1),
                  ref_shift(32'h80000000 | (32'h11111111 * (i + 1)), 3 * i + 1, 1'(i & 1)));
            cycle();
        end
        chk("bp_full", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        drive(32'hCAFEF00D, 5'd7, 1'b0, 32'hDEADBEEF);
        held = shifted_str;
        repeat (3) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            cycle();
            chk("bp_stable", shifted_str, held);
            chk("bp_valid", 32'(out_valid), 32'h1);
        end
        drain("drain_bp");
        chk("bp_count", emit_cnt - base, 5);

        // Reset mid-flight discards everything in the pipe.
        for (int i = 0; i < 3; i++) begin
            drive(32'h12345678 + i, 5'(i), 1'b0, 32'hBAD0BAD0);
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        repeat (10) begin
            cycle();
            chk("midrst_flush", 32'(out_valid), 32'h0);
        end

        // Random traffic with random backpressure; offered inputs held until accepted.
        in_valid = 1'b0;
        last_acc = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                logic [31:0] x;
                logic [4:0]  s;
                bit          a;
                x = $urandom;
                case ($urandom_range(0, 3))
                    0:       s = 5'd0;
                    1:       s = 5'd31;
                    default: s = 5'($urandom_range(0, 31));
                endcase
                a = 1'($urandom_range(0, 1));
                drive(x, s, a, ref_shift(x, int'(s), a));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("drain_random");
        chk("final_idle", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
